rob_multi_cdb: RTL and testbench

Parametrised reorder buffer for the Tomasulo core. It accepts one in-order allocation per cycle from the regfile/dispatch path and `NUM_CDB` independent out-of-order writebacks per cycle from the functional units. It retires at most one entry per cycle, in order, to the regfile. It flushes every younger entry when a mispredicted entry retires. It also provides two combinational operand-lookup ports with same-cycle writeback bypass, so the regfile can hand ready values to the reservation stations.

---
 rtl/rob_multi_cdb.sv | 195 +++++++++++++++++++
 tb/tb_rob_multi_cdb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi_cdb.sv
// rob_multi_cdb: reorder buffer with NUM_CDB writeback channels, in-order
// single retire, flush on mispredicted retire, and two bypassed lookup ports.
module rob_multi_cdb #(
   parameter int ROB_DEPTH    = 16,
   parameter int ROB_IDX_SIZE = $clog2(ROB_DEPTH),
   parameter int GPR_SIZE     = 64,
   parameter int GPR_IDX_SIZE = 5,
   parameter int NUM_CDB      = 2
) (
   input  logic                            in_clk,
   input  logic                            in_rst,
   input  logic                            in_alloc_valid,
   input  logic [GPR_IDX_SIZE-1:0]         in_alloc_dst,
   input  logic                            in_alloc_set_nzcv,
   output logic                            out_alloc_ready,
   output logic [ROB_IDX_SIZE-1:0]         out_alloc_rob_index,
   input  logic [NUM_CDB-1:0]              in_wb_valid,
   input  logic [NUM_CDB*ROB_IDX_SIZE-1:0] in_wb_rob_index,
   input  logic [NUM_CDB*GPR_SIZE-1:0]     in_wb_value,
   input  logic [NUM_CDB*4-1:0]            in_wb_nzcv,
   input  logic [NUM_CDB-1:0]              in_wb_mispred,
   input  logic [2*ROB_IDX_SIZE-1:0]       in_rd_rob_index,
   output logic [1:0]                      out_rd_ready,
   output logic [2*GPR_SIZE-1:0]           out_rd_value,
   output logic                            out_commit_valid,
   output logic [GPR_IDX_SIZE-1:0]         out_commit_reg_index,
   output logic [GPR_SIZE-1:0]             out_commit_value,
   output logic                            out_commit_set_nzcv,
   output logic [3:0]                      out_commit_nzcv,
   output logic [ROB_IDX_SIZE-1:0]         out_commit_rob_index,
   output logic                            out_flush,
   output logic [ROB_IDX_SIZE:0]           out_count
);

   localparam logic [ROB_IDX_SIZE:0]   FULL_CNT = (ROB_IDX_SIZE+1)'(ROB_DEPTH);
   localparam logic [ROB_IDX_SIZE:0]   CNT_ONE  = 1;
   localparam logic [ROB_IDX_SIZE-1:0] IDX_ONE  = 1;

   logic [ROB_DEPTH-1:0]                   valid_q, valid_d, done_q, done_d;
   logic [ROB_DEPTH-1:0]                   mispred_q, mispred_d, setf_q, setf_d;
   logic [ROB_DEPTH-1:0][GPR_IDX_SIZE-1:0] dst_q, dst_d;
   logic [ROB_DEPTH-1:0][GPR_SIZE-1:0]     value_q, value_d;
   logic [ROB_DEPTH-1:0][3:0]              nzcv_q, nzcv_d;
   logic [ROB_IDX_SIZE-1:0]                head_q, head_d, tail_q, tail_d;
   logic [ROB_IDX_SIZE:0]                  count_q, count_d;

   logic                                   cm_valid_q, cm_valid_d, cm_setf_q, cm_setf_d;
   logic                                   flush_q, flush_d;
   logic [GPR_IDX_SIZE-1:0]                cm_reg_q, cm_reg_d;
   logic [GPR_SIZE-1:0]                    cm_value_q, cm_value_d;
   logic [3:0]                             cm_nzcv_q, cm_nzcv_d;
   logic [ROB_IDX_SIZE-1:0]                cm_idx_q, cm_idx_d;

   logic                                   alloc_fire, commit_fire;
   logic [ROB_IDX_SIZE-1:0]                wb_idx, rd_idx, bp_idx;

   assign out_alloc_ready      = (count_q != FULL_CNT);
   assign out_alloc_rob_index  = tail_q;
   assign out_count            = count_q;
   assign out_commit_valid     = cm_valid_q;
   assign out_commit_reg_index = cm_reg_q;
   assign out_commit_value     = cm_value_q;
   assign out_commit_set_nzcv  = cm_setf_q;
   assign out_commit_nzcv      = cm_nzcv_q;
   assign out_commit_rob_index = cm_idx_q;
   assign out_flush            = flush_q;

   // Next-state: writeback, allocate, retire, then flush overriding everything.
   always_comb begin
      valid_d   = valid_q;
      done_d    = done_q;
      mispred_d = mispred_q;
      setf_d    = setf_q;
      dst_d     = dst_q;
      value_d   = value_q;
      nzcv_d    = nzcv_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      wb_idx    = '0;

      alloc_fire  = in_alloc_valid && out_alloc_ready;
      commit_fire = valid_q[head_q] && done_q[head_q];

      // Highest channel first so the lowest-numbered channel lands last and wins.
      for (int k = NUM_CDB-1; k >= 0; k--) begin
         wb_idx = in_wb_rob_index[k*ROB_IDX_SIZE +: ROB_IDX_SIZE];
         if (in_wb_valid[k] && valid_q[wb_idx]) begin
            done_d[wb_idx]    = 1'b1;
            mispred_d[wb_idx] = in_wb_mispred[k];
            value_d[wb_idx]   = in_wb_value[k*GPR_SIZE +: GPR_SIZE];
            nzcv_d[wb_idx]    = in_wb_nzcv[k*4 +: 4];
         end
      end

      // Tail slot is never valid while not full, so no writeback collides here.
      if (alloc_fire) begin
         valid_d[tail_q]   = 1'b1;
         done_d[tail_q]    = 1'b0;
         mispred_d[tail_q] = 1'b0;
         dst_d[tail_q]     = in_alloc_dst;
         setf_d[tail_q]    = in_alloc_set_nzcv;
         tail_d            = tail_q + IDX_ONE;
      end

      if (commit_fire) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + IDX_ONE;
      end

      case ({alloc_fire, commit_fire})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      cm_valid_d = commit_fire;
      cm_reg_d   = commit_fire ? dst_q[head_q]   : '0;
      cm_value_d = commit_fire ? value_q[head_q] : '0;
      cm_setf_d  = commit_fire && setf_q[head_q];
      cm_nzcv_d  = commit_fire ? nzcv_q[head_q]  : '0;
      cm_idx_d   = commit_fire ? head_q          : '0;
      flush_d    = commit_fire && mispred_q[head_q];

      // Mispredicted retire drops every younger entry and any same-cycle traffic.
      if (flush_d) begin
         valid_d = '0;
         head_d  = head_q + IDX_ONE;
         tail_d  = head_q + IDX_ONE;
         count_d = '0;
      end
   end

   // Operand lookup with same-cycle writeback bypass (lowest channel wins).
   always_comb begin
      out_rd_ready = '0;
      out_rd_value = '0;
      rd_idx       = '0;
      bp_idx       = '0;
      for (int p = 0; p < 2; p++) begin
         rd_idx = in_rd_rob_index[p*ROB_IDX_SIZE +: ROB_IDX_SIZE];
         out_rd_ready[p] = valid_q[rd_idx] && done_q[rd_idx];
         out_rd_value[p*GPR_SIZE +: GPR_SIZE] = value_q[rd_idx];
         for (int k = NUM_CDB-1; k >= 0; k--) begin
            bp_idx = in_wb_rob_index[k*ROB_IDX_SIZE +: ROB_IDX_SIZE];
            if (in_wb_valid[k] && (bp_idx == rd_idx) && valid_q[rd_idx]) begin
               out_rd_ready[p] = 1'b1;
               out_rd_value[p*GPR_SIZE +: GPR_SIZE] = in_wb_value[k*GPR_SIZE +: GPR_SIZE];
            end
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         valid_q    <= '0;
         done_q     <= '0;
         mispred_q  <= '0;
         setf_q     <= '0;
         dst_q      <= '0;
         value_q    <= '0;
         nzcv_q     <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         cm_valid_q <= 1'b0;
         cm_reg_q   <= '0;
         cm_value_q <= '0;
         cm_setf_q  <= 1'b0;
         cm_nzcv_q  <= '0;
         cm_idx_q   <= '0;
         flush_q    <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         done_q     <= done_d;
         mispred_q  <= mispred_d;
         setf_q     <= setf_d;
         dst_q      <= dst_d;
         value_q    <= value_d;
         nzcv_q     <= nzcv_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         cm_valid_q <= cm_valid_d;
         cm_reg_q   <= cm_reg_d;
         cm_value_q <= cm_value_d;
         cm_setf_q  <= cm_setf_d;
         cm_nzcv_q  <= cm_nzcv_d;
         cm_idx_q   <= cm_idx_d;
         flush_q    <= flush_d;
      end
   end

endmodule

// File: tb/tb_rob_multi_cdb.sv
// Directed bench for rob_multi_cdb (ROB_DEPTH=8, NUM_CDB=2).
module tb_rob_multi_cdb;

   localparam int D  = 8;
   localparam int IW = 3;
   localparam int GW = 64;

   logic           clk = 1'b0;
   logic           rst;
   logic           alloc_valid;
   logic [4:0]     alloc_dst;
   logic           alloc_setf;
   logic           alloc_ready;
   logic [IW-1:0]  alloc_idx;
   logic [1:0]     wb_valid;
   logic [2*IW-1:0] wb_idx;
   logic [2*GW-1:0] wb_val;
   logic [7:0]     wb_nzcv;
   logic [1:0]     wb_mis;
   logic [2*IW-1:0] rd_idx;
   logic [1:0]     rd_ready;
   logic [2*GW-1:0] rd_val;
   logic           cm_valid;
   logic [4:0]     cm_reg;
   logic [GW-1:0]  cm_val;
   logic           cm_setf;
   logic [3:0]     cm_nzcv;
   logic [IW-1:0]  cm_idx;
   logic           flush;
   logic [IW:0]    count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rob_multi_cdb #(.ROB_DEPTH(D), .GPR_SIZE(GW), .GPR_IDX_SIZE(5), .NUM_CDB(2)) u_dut (
      .in_clk(clk), .in_rst(rst),
      .in_alloc_valid(alloc_valid), .in_alloc_dst(alloc_dst), .in_alloc_set_nzcv(alloc_setf),
      .out_alloc_ready(alloc_ready), .out_alloc_rob_index(alloc_idx),
      .in_wb_valid(wb_valid), .in_wb_rob_index(wb_idx), .in_wb_value(wb_val),
      .in_wb_nzcv(wb_nzcv), .in_wb_mispred(wb_mis),
      .in_rd_rob_index(rd_idx), .out_rd_ready(rd_ready), .out_rd_value(rd_val),
      .out_commit_valid(cm_valid), .out_commit_reg_index(cm_reg), .out_commit_value(cm_val),
      .out_commit_set_nzcv(cm_setf), .out_commit_nzcv(cm_nzcv), .out_commit_rob_index(cm_idx),
      .out_flush(flush), .out_count(count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge; registered outputs are sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alloc_valid = 1'b0;
      wb_valid    = '0;
      wb_mis      = '0;
   endtask

   task automatic wb(input int ch, input logic [IW-1:0] idx, input logic [GW-1:0] v,
                     input logic [3:0] f, input logic m);
      wb_valid[ch]         = 1'b1;
      wb_idx[ch*IW +: IW]  = idx;
      wb_val[ch*GW +: GW]  = v;
      wb_nzcv[ch*4 +: 4]   = f;
      wb_mis[ch]           = m;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0; alloc_dst = '0; alloc_setf = 1'b0;
      wb_idx = '0; wb_val = '0; wb_nzcv = '0; rd_idx = '0;
      idle();
      do_reset();
      chk("rst_ready", 64'(alloc_ready), 64'd1);
      chk("rst_idx",   64'(alloc_idx),   64'd0);
      chk("rst_count", 64'(count),       64'd0);
      chk("rst_cmv",   64'(cm_valid),    64'd0);
      chk("rst_flush", 64'(flush),       64'd0);

      // In-order retire of out-of-order writebacks
      alloc_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         alloc_dst  = 5'(i + 1);
         alloc_setf = (i == 0);
         chk("alloc_idx", 64'(alloc_idx), 64'(i));
         tick();
      end
      idle();
      chk("cnt3", 64'(count), 64'd3);
      wb(0, 3'd2, 64'h2222, 4'h3, 1'b0); tick(); idle();
      chk("no_commit_e2", 64'(cm_valid), 64'd0);
      wb(0, 3'd0, 64'h1111, 4'hA, 1'b0); tick(); idle();
      chk("no_commit_e0", 64'(cm_valid), 64'd0);
      wb(1, 3'd1, 64'h3333, 4'h5, 1'b0); tick(); idle();
      chk("c0_valid", 64'(cm_valid), 64'd1);
      chk("c0_reg",   64'(cm_reg),   64'd1);
      chk("c0_val",   cm_val,        64'h1111);
      chk("c0_setf",  64'(cm_setf),  64'd1);
      chk("c0_nzcv",  64'(cm_nzcv),  64'hA);
      tick();
      chk("c1_reg",   64'(cm_reg),   64'd2);
      chk("c1_val",   cm_val,        64'h3333);
      chk("c1_setf",  64'(cm_setf),  64'd0);
      tick();
      chk("c2_reg",   64'(cm_reg),   64'd3);
      chk("c2_idx",   64'(cm_idx),   64'd2);
      tick();
      chk("drain_cmv", 64'(cm_valid), 64'd0);
      chk("drain_cnt", 64'(count),    64'd0);

      // Same-index priority, bypass lookups, dual distinct writebacks (entries 3,4,5)
      alloc_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         alloc_dst = 5'(i + 10);
         tick();
      end
      idle();
      wb(0, 3'd4, 64'hAA, 4'h0, 1'b0);
      wb(1, 3'd4, 64'hBB, 4'h0, 1'b0);
      rd_idx = {3'd5, 3'd4};
      #1;
      chk("byp_prio_rdy", 64'(rd_ready[0]), 64'd1);
      chk("byp_prio_val", rd_val[63:0],     64'hAA);
      chk("nrdy_e5",      64'(rd_ready[1]), 64'd0);
      tick(); idle();
      wb(1, 3'd3, 64'h55, 4'h0, 1'b0);
      wb(0, 3'd5, 64'hC5, 4'h0, 1'b0);
      rd_idx = {3'd4, 3'd3};
      #1;
      chk("byp_e3_rdy", 64'(rd_ready[0]), 64'd1);
      chk("byp_e3_val", rd_val[63:0],     64'h55);
      chk("st_e4_rdy",  64'(rd_ready[1]), 64'd1);
      chk("st_e4_val",  rd_val[127:64],   64'hAA);
      tick(); idle();
      tick();
      chk("c3_idx", 64'(cm_idx), 64'd3);
      chk("c3_val", cm_val,      64'h55);
      tick();
      chk("c4_val", cm_val,      64'hAA);
      tick();
      chk("c5_idx", 64'(cm_idx), 64'd5);
      chk("c5_val", cm_val,      64'hC5);
      tick();
      chk("c6_none", 64'(cm_valid), 64'd0);

      // Reset overrides pending commit and same-cycle alloc (entries 6,7,0)
      alloc_valid = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      idle();
      wb(0, 3'd6, 64'h66, 4'h0, 1'b0); tick(); idle();
      chk("pre_rst_cnt", 64'(count), 64'd3);
      alloc_valid = 1'b1;
      wb(0, 3'd7, 64'h77, 4'h0, 1'b0);
      rst = 1'b1; tick(); rst = 1'b0; idle();
      chk("rst2_cnt", 64'(count),       64'd0);
      chk("rst2_cmv", 64'(cm_valid),    64'd0);
      chk("rst2_idx", 64'(alloc_idx),   64'd0);
      chk("rst2_rdy", 64'(alloc_ready), 64'd1);
      tick();
      chk("rst2_nocm", 64'(cm_valid), 64'd0);

      // Full: alloc held during commit is refused, then wraps to index 0
      alloc_valid = 1'b1;
      for (int i = 0; i < D; i++) begin
         alloc_dst = 5'(i);
         tick();
      end
      chk("full_rdy", 64'(alloc_ready), 64'd0);
      chk("full_cnt", 64'(count),       64'd8);
      chk("full_idx", 64'(alloc_idx),   64'd0);
      alloc_dst = 5'd20;
      wb(0, 3'd0, 64'h10, 4'h0, 1'b0); tick();
      wb_valid = '0;
      chk("full_hold_cnt", 64'(count), 64'd8);
      tick();
      chk("full_cm_v",   64'(cm_valid),    64'd1);
      chk("full_cm_idx", 64'(cm_idx),      64'd0);
      chk("full_cm_cnt", 64'(count),       64'd7);
      chk("full_cm_rdy", 64'(alloc_ready), 64'd1);
      chk("full_cm_tl",  64'(alloc_idx),   64'd0);
      tick(); idle();
      chk("wrap_cnt", 64'(count),     64'd8);
      chk("wrap_idx", 64'(alloc_idx), 64'd1);

      // Flush on mispredicted retire of entry 1
      do_reset();
      alloc_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         alloc_dst = 5'(i + 1);
         tick();
      end
      idle();
      wb(0, 3'd1, 64'h11, 4'h0, 1'b1);
      wb(1, 3'd0, 64'h01, 4'h0, 1'b0);
      tick(); idle();
      wb(0, 3'd2, 64'h22, 4'h0, 1'b0);
      wb(1, 3'd3, 64'h33, 4'h0, 1'b0);
      tick(); idle();
      chk("fl_c0_v",   64'(cm_valid), 64'd1);
      chk("fl_c0_idx", 64'(cm_idx),   64'd0);
      chk("fl_c0_fl",  64'(flush),    64'd0);
      wb(0, 3'd4, 64'h44, 4'h0, 1'b0);
      alloc_valid = 1'b1;
      tick(); idle();
      chk("fl_c1_v",   64'(cm_valid),  64'd1);
      chk("fl_c1_idx", 64'(cm_idx),    64'd1);
      chk("fl_flush",  64'(flush),     64'd1);
      chk("fl_cnt",    64'(count),     64'd0);
      chk("fl_tail",   64'(alloc_idx), 64'd2);
      tick();
      chk("fl_after_cmv", 64'(cm_valid), 64'd0);
      chk("fl_after_fl",  64'(flush),    64'd0);
      tick();
      chk("fl_after2_cmv", 64'(cm_valid), 64'd0);
      chk("fl_after2_cnt", 64'(count),    64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
